// File: rtl/onebit_pkg.sv
// Shared types and constants for the one-bit parallel datapath.
package onebit_pkg;

    typedef enum logic {IDLE, SHIFT} s2p_state_t;

    // Default assembled word width, shared with the parallel consumer.
    localparam int ONEBIT_WIDTH = 8;

endpackage

// File: rtl/onebit_hold_reg.sv
// One-entry valid/ready holding register: loads completed words, drops them
// with an ovf pulse when the held word is neither consumed nor replaceable.
module onebit_hold_reg
    import onebit_pkg::*;
#(
    parameter int WIDTH = ONEBIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             rdy_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             vld_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        dout_d = dout_q;
        vld_d  = vld_q;
        ovf_d  = 1'b0;
        if (load_i) begin
            // A draining word frees the slot on the same edge.
            if (!vld_q || rdy_i) begin
                dout_d = word_i;
                vld_d  = 1'b1;
            end else begin
                ovf_d  = 1'b1;
            end
        end else if (vld_q && rdy_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= vld_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout_o = dout_q;
    assign vld_o  = vld_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/onebit_s2p.sv
// Serial-to-parallel front end: frames a qualified bit stream into WIDTH-bit
// words and hands them to the holding register.
module onebit_s2p
    import onebit_pkg::*;
#(
    parameter int WIDTH     = ONEBIT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_vld,
    input  logic             sof,
    input  logic             eof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             ovf,
    output logic             err,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

    s2p_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             err_q, err_d;

    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sh_n;
    logic             word_done;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
        if (MSB_FIRST != 0) return {s[WIDTH-2:0], b};
        else                return {b, s[WIDTH-1:1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        err_d     = 1'b0;
        word_done = 1'b0;
        base      = sh_q;
        cnt_n     = cnt_q + CW'(1);
        sh_n      = shift_in(sh_q, din);

        if (din_vld && (sof || state_q == SHIFT)) begin
            // sof restarts from an empty word, so the current bit becomes bit 0.
            if (sof) begin
                base  = '0;
                cnt_n = CW'(1);
                if (state_q == SHIFT && cnt_q != '0) err_d = 1'b1;
            end
            sh_n    = shift_in(base, din);
            sh_d    = sh_n;
            state_d = SHIFT;
            if (cnt_n == CNT_FULL) begin
                word_done = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d     = cnt_n;
            end
            if (eof) begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!word_done) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            err_q   <= err_d;
        end
    end

    onebit_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (word_done),
        .word_i (sh_n),
        .rdy_i  (dout_rdy),
        .dout_o (dout),
        .vld_o  (dout_vld),
        .ovf_o  (ovf)
    );

    assign err  = err_q;
    assign busy = (state_q == SHIFT);

endmodule

// File: tb/tb_onebit_s2p.sv
// Bench for onebit_s2p: both bit orders run side by side against a
// queue-based frame model.
module tb_onebit_s2p;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         din = 1'b0, din_vld = 1'b0, sof = 1'b0, eof = 1'b0, dout_rdy = 1'b0;
    logic [W-1:0] dout_m, dout_l;
    logic         vld_m, vld_l, ovf_m, ovf_l, err_m, err_l, busy_m, busy_l;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit           q[$];
    bit           m_in_frame;
    logic [W-1:0] m_dout_m, m_dout_l;
    bit           m_vld, m_ovf, m_err;

    always #5 clk = ~clk;

    onebit_s2p #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .sof(sof), .eof(eof),
        .dout(dout_m), .dout_vld(vld_m), .dout_rdy(dout_rdy),
        .ovf(ovf_m), .err(err_m), .busy(busy_m)
    );

    onebit_s2p #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .sof(sof), .eof(eof),
        .dout(dout_l), .dout_vld(vld_l), .dout_rdy(dout_rdy),
        .ovf(ovf_l), .err(err_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_in_frame = 1'b0;
        m_dout_m = '0;
        m_dout_l = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit s, input bit e, input bit r);
        bit           done;
        logic [W-1:0] wm, wl;
        done  = 1'b0;
        wm    = '0;
        wl    = '0;
        m_ovf = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in_frame && q.size() != 0) m_err = 1'b1;
                q.delete();
                m_in_frame = 1'b1;
            end
            if (m_in_frame) begin
                q.push_back(d);
                if (q.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = q[i];
                        wl[i]     = q[i];
                    end
                    q.delete();
                end
                if (e) begin
                    if (!done) m_err = 1'b1;
                    q.delete();
                    m_in_frame = 1'b0;
                end
            end
        end
        if (done) begin
            if (!m_vld || r) begin
                m_vld    = 1'b1;
                m_dout_m = wm;
                m_dout_l = wl;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("dout_msb", dout_m, m_dout_m);
        chk("dout_lsb", dout_l, m_dout_l);
        chk("vld_msb", vld_m, m_vld);
        chk("vld_lsb", vld_l, m_vld);
        chk("ovf_msb", ovf_m, m_ovf);
        chk("ovf_lsb", ovf_l, m_ovf);
        chk("err_msb", err_m, m_err);
        chk("err_lsb", err_l, m_err);
        chk("busy_msb", busy_m, m_in_frame);
        chk("busy_lsb", busy_l, m_in_frame);
    endtask

    task automatic cycle(input bit d, input bit v, input bit s, input bit e, input bit r);
        din = d; din_vld = v; sof = s; eof = e; dout_rdy = r;
        @(posedge clk);
        model_step(d, v, s, e, r);
        #1;
        check_all();
    endtask

    // Sends w MSB first; rdy applies to every bit except the last, which uses rdy_last.
    task automatic send_word(input logic [W-1:0] w, input bit with_sof, input bit rdy,
                             input bit rdy_last, input bit eof_last);
        for (int i = W - 1; i >= 0; i--)
            cycle(w[i], 1'b1, with_sof && (i == W - 1), eof_last && (i == 0),
                  (i == 0) ? rdy_last : rdy);
    endtask

    // Asynchronous reset dropped mid-cycle, released on the falling edge.
    task automatic do_reset();
        din_vld = 1'b0; sof = 1'b0; eof = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_dout_zero", dout_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // B2 / 4D basic word with dout_rdy high
        cycle(1, 1, 1, 0, 1);
        for (int i = 1; i < W; i++) cycle((8'hB2 >> (W - 1 - i)) & 1, 1, 0, 0, 1);
        chk("word_b2", dout_m, 8'hB2);
        chk("word_4d", dout_l, 8'h4D);
        chk("word_vld", vld_m, 1);
        cycle(0, 0, 0, 0, 1);
        chk("word_vld_once", vld_m, 0);

        // back-to-back words into a stalled holding register
        send_word(8'hA5, 1, 0, 0, 0);
        send_word(8'h3C, 0, 0, 0, 0);
        chk("ovf_second_word", ovf_m, 1);
        chk("held_a5", dout_m, 8'hA5);
        cycle(0, 0, 0, 0, 0);
        chk("ovf_one_cycle", ovf_m, 0);
        cycle(0, 0, 0, 0, 1);
        chk("a5_drained", vld_m, 0);

        // simultaneous drain and load
        send_word(8'h5A, 0, 0, 0, 0);
        send_word(8'hC3, 0, 0, 1, 0);
        chk("swap_no_ovf", ovf_m, 0);
        chk("swap_c3", dout_m, 8'hC3);
        cycle(0, 0, 0, 0, 1);

        // sof restart mid-word, then a clean word
        cycle(1, 1, 1, 0, 1);
        cycle(0, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        send_word(8'h96, 1, 1, 1, 0);
        chk("restart_word", dout_m, 8'h96);
        cycle(0, 0, 0, 0, 1);

        // eof on the fifth bit of a frame
        cycle(1, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 1, 1);
        chk("eof5_err", err_m, 1);
        chk("eof5_idle", busy_m, 0);
        chk("eof5_nodeliver", vld_m, 0);

        // one-bit frame
        cycle(1, 1, 1, 1, 1);
        chk("sof_eof_err", err_m, 1);

        // reset mid-word, reset while holding, then bits without sof
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        do_reset();
        send_word(8'hE7, 1, 0, 0, 0);
        chk("hold_before_rst", vld_m, 1);
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 1);
        chk("no_sof_ignored", busy_m, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 1),
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 29) == 0,
                      $urandom_range(0, 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
